// File: rtl/sys_defs.sv
// Shared front-end definitions: fetch/decode packet layout and queue sizing.
package sys_defs;

   localparam int XLEN     = 32;
   localparam int FB_DEPTH = 8;

   typedef struct packed {
      logic [31:0]     inst;
      logic [XLEN-1:0] PC;
      logic [XLEN-1:0] NPC;
      logic            valid;
   } IF_ID_PACKET;

endpackage

// File: rtl/fetch_buffer.sv
// Circular instruction queue between 3-wide fetch and dispatch.
// Accepts up to 3 in-order packets per cycle and presents the oldest 3.
module fetch_buffer
   import sys_defs::*;
#(
   parameter int DEPTH = FB_DEPTH
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              squash,
   input  IF_ID_PACKET [2:0] if_packet_in,
   input  logic [1:0]        dispatch_num,
   output logic              in_ready,
   output IF_ID_PACKET [2:0] if_packet_out,
   output logic [1:0]        num_valid
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0] head, tail;
   logic [CW-1:0] count;
   logic [1:0]    enq_n, wr_n, deq_n;
   IF_ID_PACKET   mem [DEPTH];

   function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] base, input logic [1:0] off);
      return base + PW'(off);
   endfunction

   function automatic logic slot_valid(input logic [CW-1:0] cnt, input logic [1:0] off);
      return cnt > CW'(off);
   endfunction

   // Decided from the registered count only, so fetch never sees a path through dispatch.
   assign in_ready = (CW'(DEPTH) - count) >= CW'(3);

   // NOTE: every variable gets a default before any branch so no latch is inferred.
   always_comb begin
      enq_n = 2'd0;
      if (in_ready && if_packet_in[2].valid) begin
         if (!if_packet_in[1].valid)      enq_n = 2'd1;
         else if (!if_packet_in[0].valid) enq_n = 2'd2;
         else                             enq_n = 2'd3;
      end
   end

   assign wr_n  = squash ? 2'd0 : enq_n;
   assign deq_n = (CW'(dispatch_num) > count) ? count[1:0] : dispatch_num;

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (squash) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= head + PW'(deq_n);
         tail  <= tail + PW'(wr_n);
         count <= count + CW'(wr_n) - CW'(deq_n);
      end
   end

   // NOTE: storage is not reset; entries outside [head, head+count) are never shown.
   always_ff @(posedge clock) begin
      for (int i = 0; i < 3; i++) begin
         if (2'(i) < wr_n) mem[ptr_add(tail, 2'(i))] <= if_packet_in[2-i];
      end
   end

   always_comb begin
      if_packet_out = '0;
      for (int k = 0; k < 3; k++) begin
         if (slot_valid(count, 2'(2 - k))) begin
            if_packet_out[k]       = mem[ptr_add(head, 2'(2 - k))];
            if_packet_out[k].valid = 1'b1;
         end
      end
   end

   assign num_valid = (count >= CW'(3)) ? 2'd3 : count[1:0];

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_fetch_buffer;
   import sys_defs::*;

   localparam int DEPTH = 8;

   logic              clock = 1'b0;
   logic              reset = 1'b0;
   logic              squash = 1'b0;
   IF_ID_PACKET [2:0] if_packet_in = '0;
   logic [1:0]        dispatch_num = 2'd0;
   logic              in_ready;
   IF_ID_PACKET [2:0] if_packet_out;
   logic [1:0]        num_valid;

   int n_vec  = 0;
   int n_fail = 0;

   IF_ID_PACKET model_q[$];

   fetch_buffer #(.DEPTH(DEPTH)) dut (
      .clock(clock), .reset(reset), .squash(squash), .if_packet_in(if_packet_in),
      .dispatch_num(dispatch_num), .in_ready(in_ready),
      .if_packet_out(if_packet_out), .num_valid(num_valid)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic IF_ID_PACKET mk_pkt(input int pc, input logic v);
      IF_ID_PACKET p;
      p.inst  = $urandom;
      p.PC    = XLEN'(pc);
      p.NPC   = XLEN'(pc + 4);
      p.valid = v;
      return p;
   endfunction

   // Compare every output against what the reference queue implies.
   task automatic compare_all(input string tag);
      IF_ID_PACKET exp_p;
      int sz = model_q.size();
      check({tag, ".num_valid"}, 128'(num_valid), 128'((sz > 3) ? 3 : sz));
      check({tag, ".in_ready"}, 128'(in_ready), 128'(DEPTH - sz >= 3));
      for (int k = 0; k < 3; k++) begin
         exp_p = '0;
         if (2 - k < sz) begin
            exp_p = model_q[2 - k];
            exp_p.valid = 1'b1;
         end
         check($sformatf("%s.out%0d", tag, k), 128'(if_packet_out[k]), 128'(exp_p));
      end
   endtask

   // Apply current inputs across one rising edge, advance the model, compare at the falling edge.
   task automatic cycle(input string tag);
      bit ready = (DEPTH - model_q.size()) >= 3;
      int dn = int'(dispatch_num);
      @(posedge clock);
      if (squash) begin
         model_q.delete();
      end else begin
         for (int i = 0; i < dn && model_q.size() > 0; i++) void'(model_q.pop_front());
         if (ready) begin
            for (int s = 2; s >= 0; s--) begin
               if (!if_packet_in[s].valid) break;
               model_q.push_back(if_packet_in[s]);
            end
         end
      end
      @(negedge clock);
      compare_all(tag);
   endtask

   task automatic drive(input logic sq, input int pc, input logic [2:0] v, input logic [1:0] dn);
      squash = sq;
      if_packet_in[2] = mk_pkt(pc, v[2]);
      if_packet_in[1] = mk_pkt(pc + 4, v[1]);
      if_packet_in[0] = mk_pkt(pc + 8, v[0]);
      dispatch_num = dn;
   endtask

   initial begin
      // Reset then idle
      repeat (2) @(negedge clock);
      check("rst.num_valid", 128'(num_valid), 128'(0));
      check("rst.in_ready", 128'(in_ready), 128'(1));
      check("rst.out", 128'(if_packet_out), 128'(0));
      reset = 1'b1;
      cycle("idle");

      // Fill
      drive(0, 0, 3'b111, 2'd0);
      cycle("fill");
      check("fill.pc2", 128'(if_packet_out[2].PC), 128'(0));
      check("fill.pc1", 128'(if_packet_out[1].PC), 128'(4));
      check("fill.pc0", 128'(if_packet_out[0].PC), 128'(8));

      // Back-pressure: count reaches 6, next group dropped while 3 are dispatched
      drive(0, 12, 3'b111, 2'd0);
      cycle("bp6");
      check("bp6.in_ready", 128'(in_ready), 128'(0));
      drive(0, 24, 3'b111, 2'd3);
      cycle("bpdrop");
      check("bpdrop.num_valid", 128'(num_valid), 128'(3));
      check("bpdrop.pc2", 128'(if_packet_out[2].PC), 128'(12));

      // Drain, then non-contiguous input: only slot 2 accepted
      drive(0, 0, 3'b000, 2'd3);
      cycle("drain");
      drive(0, 100, 3'b101, 2'd0);
      cycle("partial");
      check("partial.num_valid", 128'(num_valid), 128'(1));
      check("partial.pc2", 128'(if_packet_out[2].PC), 128'(100));

      // Wrap: reach head=6 with count=4 so reads straddle index 7 -> 0
      drive(1, 0, 3'b000, 2'd0);
      cycle("sq0");
      drive(0, 300, 3'b111, 2'd0); cycle("wrapA");
      drive(0, 312, 3'b111, 2'd3); cycle("wrapB");
      drive(0, 200, 3'b111, 2'd3); cycle("wrapC");
      drive(0, 212, 3'b100, 2'd0); cycle("wrapD");
      check("wrap.pc2", 128'(if_packet_out[2].PC), 128'(200));
      check("wrap.pc1", 128'(if_packet_out[1].PC), 128'(204));
      check("wrap.pc0", 128'(if_packet_out[0].PC), 128'(208));
      drive(0, 0, 3'b000, 2'd3); cycle("over1");
      check("over1.num_valid", 128'(num_valid), 128'(1));
      cycle("over2");
      check("over2.num_valid", 128'(num_valid), 128'(0));
      cycle("over3");

      // Squash with concurrent traffic at count=5
      drive(0, 400, 3'b111, 2'd0); cycle("sqfill3");
      drive(0, 412, 3'b110, 2'd0); cycle("sqfill5");
      drive(1, 500, 3'b111, 2'd2); cycle("squash");
      check("squash.num_valid", 128'(num_valid), 128'(0));
      check("squash.in_ready", 128'(in_ready), 128'(1));

      // Asynchronous reset mid-cycle
      drive(0, 600, 3'b111, 2'd0); cycle("prerst");
      #2 reset = 1'b0;
      #1;
      model_q.delete();
      check("arst.out", 128'(if_packet_out), 128'(0));
      check("arst.num_valid", 128'(num_valid), 128'(0));
      check("arst.in_ready", 128'(in_ready), 128'(1));
      @(negedge clock);
      reset = 1'b1;
      drive(0, 0, 3'b000, 2'd0);
      cycle("postrst");

      // Random traffic
      for (int n = 0; n < 400; n++) begin
         drive(($urandom_range(0, 29) == 0), int'($urandom_range(0, 1023)) * 4,
               3'($urandom), 2'($urandom));
         cycle("rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
